// File: rtl/csr_sys_exec.sv
// Multi-cycle execute stage for RISC-V SYSTEM instructions: CSR read-modify-write,
// ECALL/EBREAK/illegal traps and MRET, with a valid/ready response towards writeback.
module csr_sys_exec #(
    parameter int XLEN          = 32,
    parameter int CAUSE_ILLEGAL = 2,
    parameter int CAUSE_BREAK   = 3,
    parameter int CAUSE_ECALL_M = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_funct3,
    input  logic [11:0]     in_csr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [4:0]      in_zimm,
    input  logic            in_rs1_zero,
    input  logic            in_rd_zero,
    input  logic [XLEN-1:0] in_pc,
    output logic [31:0]     csr_addr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_wen,
    output logic            exception,
    output logic [XLEN-1:0] exception_pc,
    output logic [XLEN-1:0] exception_cause,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_rd_val,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_RESP} state_e;
    typedef enum logic [1:0] {
        KIND_CSR    = 2'd0,
        KIND_ECALL  = 2'd1,
        KIND_MRET   = 2'd2,
        KIND_EBREAK = 2'd3
    } kind_e;

    state_e          state, state_next;
    kind_e           kind_q;
    logic [2:0]      funct3_q;
    logic [11:0]     csr_q;
    logic [XLEN-1:0] rs1_val_q, pc_q, rdata_q, wdata_q, cause_q;
    logic [4:0]      zimm_q;
    logic            rs1_zero_q, rd_zero_q, wen_q, trap_q, legal_q;

    logic            is_csr, legal, src_nonzero, wen_next, trap_next;
    logic [XLEN-1:0] src, wdata_next, cause_next;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        csr_wen    = 1'b0;
        exception  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) state_next = ST_READ;
            end
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: begin
                csr_wen    = wen_q;
                exception  = trap_q;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
        endcase
    end

    // Decode of the latched instruction, evaluated while the CSR file is being read.
    always_comb begin
        is_csr      = (kind_q == KIND_CSR);
        legal       = is_csr && (funct3_q[1:0] != 2'b00) &&
                      (csr_q inside {12'h300, 12'h305, 12'h341, 12'h342});
        src         = funct3_q[2] ? XLEN'(zimm_q) : rs1_val_q;
        src_nonzero = funct3_q[2] ? (zimm_q != 5'd0) : !rs1_zero_q;
        unique case (funct3_q[1:0])
            2'b10:   wdata_next = csr_rdata | src;
            2'b11:   wdata_next = csr_rdata & ~src;
            default: wdata_next = src;
        endcase
        // CSRRW/CSRRWI always write; set/clear forms only when the source can change bits.
        wen_next  = legal && ((funct3_q[1:0] == 2'b01) || src_nonzero);
        trap_next = (is_csr && !legal) || (kind_q == KIND_ECALL) || (kind_q == KIND_EBREAK);
        unique case (kind_q)
            KIND_ECALL:  cause_next = XLEN'(CAUSE_ECALL_M);
            KIND_EBREAK: cause_next = XLEN'(CAUSE_BREAK);
            KIND_CSR:    cause_next = legal ? '0 : XLEN'(CAUSE_ILLEGAL);
            default:     cause_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register, latched fields included, is reset so an aborted op leaves nothing behind.
        if (rst) begin
            kind_q       <= KIND_CSR;
            funct3_q     <= '0;
            csr_q        <= '0;
            rs1_val_q    <= '0;
            zimm_q       <= '0;
            rs1_zero_q   <= 1'b0;
            rd_zero_q    <= 1'b0;
            pc_q         <= '0;
            rdata_q      <= '0;
            wdata_q      <= '0;
            cause_q      <= '0;
            wen_q        <= 1'b0;
            trap_q       <= 1'b0;
            legal_q      <= 1'b0;
            out_rd_wen   <= 1'b0;
            out_rd_val   <= '0;
            out_redirect <= 1'b0;
            out_target   <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            kind_q     <= kind_e'(in_kind);
            funct3_q   <= in_funct3;
            csr_q      <= in_csr;
            rs1_val_q  <= in_rs1_val;
            zimm_q     <= in_zimm;
            rs1_zero_q <= in_rs1_zero;
            rd_zero_q  <= in_rd_zero;
            pc_q       <= in_pc;
        end else if (state == ST_READ) begin
            rdata_q <= csr_rdata;
            wdata_q <= wdata_next;
            cause_q <= cause_next;
            wen_q   <= wen_next;
            trap_q  <= trap_next;
            legal_q <= legal;
        end else if (state == ST_EXEC) begin
            out_rd_wen   <= legal_q && !rd_zero_q;
            out_rd_val   <= (kind_q == KIND_CSR) ? rdata_q : '0;
            out_redirect <= trap_q || (kind_q == KIND_MRET);
            out_target   <= trap_q ? mtvec_in : (kind_q == KIND_MRET) ? mepc_in : '0;
        end
    end

    assign csr_addr        = {20'd0, csr_q};
    assign csr_wdata       = wdata_q;
    assign exception_pc    = pc_q;
    assign exception_cause = cause_q;
endmodule
